// File: rtl/mem_arbiter.sv
// Two-port (CPU / debug) arbiter onto one single-port program memory, one transaction at a time.
// Latency: write ack 2 cycles after grant sample, read ack 2+READ_LATENCY; the losing port simply waits with req held.
module mem_arbiter #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 16,
  parameter int READ_LATENCY = 0,
  parameter int DBG_PRIORITY = 0
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  cpu_req,
  input  logic                  cpu_write,
  input  logic [ADDR_WIDTH-1:0] cpu_address,
  input  logic [DATA_WIDTH-1:0] cpu_data_in,
  output logic                  cpu_ack,
  output logic [DATA_WIDTH-1:0] cpu_data_out,

  input  logic                  dbg_req,
  input  logic                  dbg_write,
  input  logic [ADDR_WIDTH-1:0] dbg_address,
  input  logic [DATA_WIDTH-1:0] dbg_data_in,
  output logic                  dbg_ack,
  output logic [DATA_WIDTH-1:0] dbg_data_out,

  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  mem_write,
  output logic                  mem_read,
  input  logic [DATA_WIDTH-1:0] mem_data_out,

  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] data;
  } req_t;

  localparam logic [1:0] LAST_COUNT = 2'(READ_LATENCY);

  state_t     state;
  logic       grant;        // 0 = cpu, 1 = dbg
  logic       last_grant;
  logic       is_write;
  logic [1:0] count;

  req_t cpu_hdr;
  req_t dbg_hdr;
  req_t win_hdr;
  logic pick_dbg;

  assign cpu_hdr = '{write: cpu_write, address: cpu_address, data: cpu_data_in};
  assign dbg_hdr = '{write: dbg_write, address: dbg_address, data: dbg_data_in};

  // A tie goes to the port that did not win last time, unless debug is pinned.
  always_comb begin
    pick_dbg = 1'b0;
    if (cpu_req && dbg_req) begin
      pick_dbg = (DBG_PRIORITY != 0) ? 1'b1 : !last_grant;
    end else begin
      pick_dbg = dbg_req;
    end
  end

  assign win_hdr = pick_dbg ? dbg_hdr : cpu_hdr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      grant        <= 1'b0;
      last_grant   <= 1'b1;
      is_write     <= 1'b0;
      count        <= 2'd0;
      mem_address  <= '0;
      mem_data_in  <= '0;
      mem_write    <= 1'b0;
      mem_read     <= 1'b0;
      cpu_ack      <= 1'b0;
      dbg_ack      <= 1'b0;
      cpu_data_out <= '0;
      dbg_data_out <= '0;
      busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req || dbg_req) begin
            state       <= ACCESS;
            busy        <= 1'b1;
            grant       <= pick_dbg;
            last_grant  <= pick_dbg;
            is_write    <= win_hdr.write;
            mem_address <= win_hdr.address;
            mem_data_in <= win_hdr.data;
            mem_write   <= win_hdr.write;
            mem_read    <= !win_hdr.write;
            count       <= 2'd0;
          end
        end

        ACCESS: begin
          if (is_write) begin
            mem_write <= 1'b0;
            cpu_ack   <= !grant;
            dbg_ack   <= grant;
            state     <= ACK;
          end else if (count == LAST_COUNT) begin
            // Memory output is only trusted on the final access cycle.
            mem_read <= 1'b0;
            if (grant) begin
              dbg_data_out <= mem_data_out;
            end else begin
              cpu_data_out <= mem_data_out;
            end
            cpu_ack <= !grant;
            dbg_ack <= grant;
            state   <= ACK;
          end else begin
            count <= count + 2'd1;
          end
        end

        ACK: begin
          cpu_ack <= 1'b0;
          dbg_ack <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end

        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          mem_write <= 1'b0;
          mem_read  <= 1'b0;
          cpu_ack   <= 1'b0;
          dbg_ack   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: three arbiter instances (RL=0 round-robin, RL=2 round-robin, RL=0 debug-priority)
// driven from shared requester inputs, each backed by its own memory model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_write, dbg_req, dbg_write;
  logic [15:0] cpu_address, cpu_data_in, dbg_address, dbg_data_in;

  logic        c_ack0, d_ack0, mw0, mr0, busy0;
  logic [15:0] c_do0, d_do0, ma0, mdi0, mdo0;
  logic        c_ack1, d_ack1, mw1, mr1, busy1;
  logic [15:0] c_do1, d_do1, ma1, mdi1, mdo1;
  logic        c_ack2, d_ack2, mw2, mr2, busy2;
  logic [15:0] c_do2, d_do2, ma2, mdi2, mdo2;

  logic [15:0] mem0 [256];
  logic [15:0] mem1 [256];
  logic [15:0] mem2 [256];
  logic [15:0] rd1_q, rd2_q;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] init_val(input logic [7:0] a);
    if (a == 8'h0A) return 16'h01e6;
    return {a, a} ^ 16'h5a5a;
  endfunction

  // Memory models reload their contents whenever reset is held.
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 256; i++) begin
        mem0[i] <= init_val(8'(i));
        mem1[i] <= init_val(8'(i));
        mem2[i] <= init_val(8'(i));
      end
    end else begin
      if (mw0) mem0[ma0[7:0]] <= mdi0;
      if (mw1) mem1[ma1[7:0]] <= mdi1;
      if (mw2) mem2[ma2[7:0]] <= mdi2;
    end
    rd1_q <= mem1[ma1[7:0]];
    rd2_q <= rd1_q;
  end

  assign mdo0 = mem0[ma0[7:0]];
  assign mdo1 = rd2_q;
  assign mdo2 = mem2[ma2[7:0]];

  mem_arbiter #(.READ_LATENCY(0), .DBG_PRIORITY(0)) u_rr (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_address(cpu_address), .cpu_data_in(cpu_data_in),
    .cpu_ack(c_ack0), .cpu_data_out(c_do0),
    .dbg_req(dbg_req), .dbg_write(dbg_write), .dbg_address(dbg_address), .dbg_data_in(dbg_data_in),
    .dbg_ack(d_ack0), .dbg_data_out(d_do0),
    .mem_address(ma0), .mem_data_in(mdi0), .mem_write(mw0), .mem_read(mr0), .mem_data_out(mdo0),
    .busy(busy0));

  mem_arbiter #(.READ_LATENCY(2), .DBG_PRIORITY(0)) u_rl2 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_address(cpu_address), .cpu_data_in(cpu_data_in),
    .cpu_ack(c_ack1), .cpu_data_out(c_do1),
    .dbg_req(dbg_req), .dbg_write(dbg_write), .dbg_address(dbg_address), .dbg_data_in(dbg_data_in),
    .dbg_ack(d_ack1), .dbg_data_out(d_do1),
    .mem_address(ma1), .mem_data_in(mdi1), .mem_write(mw1), .mem_read(mr1), .mem_data_out(mdo1),
    .busy(busy1));

  mem_arbiter #(.READ_LATENCY(0), .DBG_PRIORITY(1)) u_pri (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_address(cpu_address), .cpu_data_in(cpu_data_in),
    .cpu_ack(c_ack2), .cpu_data_out(c_do2),
    .dbg_req(dbg_req), .dbg_write(dbg_write), .dbg_address(dbg_address), .dbg_data_in(dbg_data_in),
    .dbg_ack(d_ack2), .dbg_data_out(d_do2),
    .mem_address(ma2), .mem_data_in(mdi2), .mem_write(mw2), .mem_read(mr2), .mem_data_out(mdo2),
    .busy(busy2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset   = 1'b0;
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    cpu_req = 1'b1; cpu_write = 1'b0; cpu_address = 16'h0000; cpu_data_in = 16'h0000;
    dbg_req = 1'b1; dbg_write = 1'b0; dbg_address = 16'h0000; dbg_data_in = 16'h0000;

    // Reset held with both requests pending: nothing may happen.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_cpu_ack", 32'(c_ack0), 0);
      check("rst_dbg_ack", 32'(d_ack0), 0);
      check("rst_mem_write", 32'(mw0), 0);
      check("rst_busy", 32'(busy0), 0);
    end
    check("rst_mem_addr", 32'(ma0), 0);
    cpu_req = 1'b0; dbg_req = 1'b0;
    reset = 1'b1;
    tick();

    // CPU read, RL=0, address 0x000A.
    cpu_req = 1'b1; cpu_write = 1'b0; cpu_address = 16'h000A;
    tick();
    check("rd_access_mem_read", 32'(mr0), 1);
    check("rd_access_busy", 32'(busy0), 1);
    check("rd_access_ack", 32'(c_ack0), 0);
    check("rd_access_addr", 32'(ma0), 32'h000A);
    tick();
    check("rd_cpu_ack", 32'(c_ack0), 1);
    check("rd_dbg_ack", 32'(d_ack0), 0);
    check("rd_cpu_data", 32'(c_do0), 32'h01e6);
    check("rd_mem_read_off", 32'(mr0), 0);
    cpu_req = 1'b0;
    tick();
    check("rd_ack_one_cycle", 32'(c_ack0), 0);
    check("rd_idle_busy", 32'(busy0), 0);

    // Debug write 0x0021 to 0x0005.
    dbg_req = 1'b1; dbg_write = 1'b1; dbg_address = 16'h0005; dbg_data_in = 16'h0021;
    tick();
    check("wr_mem_write", 32'(mw0), 1);
    check("wr_mem_addr", 32'(ma0), 32'h0005);
    check("wr_mem_din", 32'(mdi0), 32'h0021);
    check("wr_dbg_ack_early", 32'(d_ack0), 0);
    tick();
    check("wr_mem_write_once", 32'(mw0), 0);
    check("wr_dbg_ack", 32'(d_ack0), 1);
    check("wr_cpu_ack", 32'(c_ack0), 0);
    dbg_req = 1'b0;
    tick();
    check("wr_dbg_ack_drop", 32'(d_ack0), 0);
    check("wr_dbg_dout_kept", 32'(d_do0), 0);

    // Read back through the CPU port; CPU data_out must update, debug's must not.
    cpu_req = 1'b1; cpu_write = 1'b0; cpu_address = 16'h0005;
    tick();
    tick();
    check("rb_cpu_ack", 32'(c_ack0), 1);
    check("rb_cpu_data", 32'(c_do0), 32'h0021);
    check("rb_dbg_dout", 32'(d_do0), 0);
    cpu_req = 1'b0;
    tick();

    // Both ports requesting continuously after reset: RR alternates starting with cpu,
    // priority instance serves debug every time.
    do_reset();
    cpu_req = 1'b1; cpu_write = 1'b0; cpu_address = 16'h0010;
    dbg_req = 1'b1; dbg_write = 1'b0; dbg_address = 16'h0020;
    for (int t = 1; t <= 12; t++) begin
      tick();
      check($sformatf("rr_cpu_ack_t%0d", t), 32'(c_ack0), 32'((t == 2) || (t == 8)));
      check($sformatf("rr_dbg_ack_t%0d", t), 32'(d_ack0), 32'((t == 5) || (t == 11)));
      check($sformatf("pri_cpu_ack_t%0d", t), 32'(c_ack2), 0);
      check($sformatf("pri_dbg_ack_t%0d", t), 32'(d_ack2), 32'((t % 3) == 2));
      if (t == 2) check("rr_cpu_data", 32'(c_do0), 32'(init_val(8'h10)));
      if (t == 5) check("rr_dbg_data", 32'(d_do0), 32'(init_val(8'h20)));
      if (t == 5) check("pri_dbg_data", 32'(d_do2), 32'(init_val(8'h20)));
    end

    // READ_LATENCY=2: three access cycles, data taken on the last one.
    do_reset();
    cpu_req = 1'b1; cpu_write = 1'b0; cpu_address = 16'h0033;
    for (int t = 1; t <= 3; t++) begin
      tick();
      check($sformatf("rl2_mem_read_t%0d", t), 32'(mr1), 1);
      check($sformatf("rl2_ack_t%0d", t), 32'(c_ack1), 0);
    end
    tick();
    check("rl2_cpu_ack", 32'(c_ack1), 1);
    check("rl2_mem_read_off", 32'(mr1), 0);
    check("rl2_cpu_data", 32'(c_do1), 32'(init_val(8'h33)));
    cpu_req = 1'b0;
    tick();
    check("rl2_ack_drop", 32'(c_ack1), 0);

    // Reset landing in the ACCESS cycle of a debug write.
    do_reset();
    dbg_req = 1'b1; dbg_write = 1'b1; dbg_address = 16'h0007; dbg_data_in = 16'hBEEF;
    tick();
    check("abort_mem_write_pre", 32'(mw0), 1);
    reset = 1'b0;
    cpu_req = 1'b1; cpu_write = 1'b0; cpu_address = 16'h000A;
    tick();
    check("abort_mem_write", 32'(mw0), 0);
    check("abort_dbg_ack", 32'(d_ack0), 0);
    check("abort_busy", 32'(busy0), 0);
    reset = 1'b1;
    tick();
    check("abort_grant_addr", 32'(ma0), 32'h000A);
    check("abort_grant_read", 32'(mr0), 1);
    check("abort_no_write", 32'(mw0), 0);
    tick();
    check("abort_cpu_ack", 32'(c_ack0), 1);
    check("abort_dbg_ack2", 32'(d_ack0), 0);
    check("abort_cpu_data", 32'(c_do0), 32'h01e6);
    cpu_req = 1'b0; dbg_req = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
